// File: rtl/chess_clock_pkg.sv
// -----------------------------------------------------------------------------
// chess_clock_pkg
// Shared types and helpers for the two-player chess clock.
//   bcd_t       : one BCD digit (4 bits)
//   SEG_0..SEG_9: active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}
//   SEG_BLANK   : all segments off
//   bcd_to_seg  : digit to segment pattern, non-decimal codes blank the digit
// -----------------------------------------------------------------------------
package chess_clock_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam bcd_t SEC_ONES_MAX = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t MIN_ONES_MAX = 4'd9;
  localparam bcd_t MIN_TENS_MAX = 4'd9;

  // Decode one digit; anything outside 0-9 shows as a dark digit so a
  // corrupted counter never masquerades as a valid time.
  function automatic logic [6:0] bcd_to_seg(input bcd_t digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/chess_clock_player_timer.sv
// -----------------------------------------------------------------------------
// player_timer
// Elapsed-time MM:SS counter for one player, saturating at 99:59.
//   clk_i       : system clock
//   clr_i       : synchronous active-high clear (counter to 00:00, flag low)
//   step_i      : advance one second on this edge
//   freeze_i    : game over, ignore steps
//   secOnes_o   : seconds units digit
//   secTens_o   : seconds tens digit
//   minOnes_o   : minutes units digit
//   minTens_o   : minutes tens digit
//   overflow_o  : sticky, set by a step that arrives at 99:59
// -----------------------------------------------------------------------------
module player_timer
  import chess_clock_pkg::*;
(
  input  logic       clk_i,
  input  logic       clr_i,
  input  logic       step_i,
  input  logic       freeze_i,
  output logic [3:0] secOnes_o,
  output logic [3:0] secTens_o,
  output logic [3:0] minOnes_o,
  output logic [3:0] minTens_o,
  output logic       overflow_o
);

  bcd_t secOnes_q, secOnes_d;
  bcd_t secTens_q, secTens_d;
  bcd_t minOnes_q, minOnes_d;
  bcd_t minTens_q, minTens_d;
  logic overflow_q, overflow_d;
  logic atMax;

  assign atMax = (minTens_q == MIN_TENS_MAX) && (minOnes_q == MIN_ONES_MAX) &&
                 (secTens_q == SEC_TENS_MAX) && (secOnes_q == SEC_ONES_MAX);

  // Next-state: ripple the carry through the four digits on a step. At 99:59
  // the time stays put and the overflow flag latches instead of wrapping.
  always_comb begin
    secOnes_d  = secOnes_q;
    secTens_d  = secTens_q;
    minOnes_d  = minOnes_q;
    minTens_d  = minTens_q;
    overflow_d = overflow_q;
    if (step_i && !freeze_i) begin
      if (atMax) begin
        overflow_d = 1'b1;
      end else if (secOnes_q != SEC_ONES_MAX) begin
        secOnes_d = secOnes_q + 4'd1;
      end else begin
        secOnes_d = 4'd0;
        if (secTens_q != SEC_TENS_MAX) begin
          secTens_d = secTens_q + 4'd1;
        end else begin
          secTens_d = 4'd0;
          if (minOnes_q != MIN_ONES_MAX) begin
            minOnes_d = minOnes_q + 4'd1;
          end else begin
            minOnes_d = 4'd0;
            minTens_d = minTens_q + 4'd1;
          end
        end
      end
    end
  end

  // State register; clear beats every other input.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      secOnes_q  <= 4'd0;
      secTens_q  <= 4'd0;
      minOnes_q  <= 4'd0;
      minTens_q  <= 4'd0;
      overflow_q <= 1'b0;
    end else begin
      secOnes_q  <= secOnes_d;
      secTens_q  <= secTens_d;
      minOnes_q  <= minOnes_d;
      minTens_q  <= minTens_d;
      overflow_q <= overflow_d;
    end
  end

  assign secOnes_o  = secOnes_q;
  assign secTens_o  = secTens_q;
  assign minOnes_o  = minOnes_q;
  assign minTens_o  = minTens_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/chess_clock_top.sv
// -----------------------------------------------------------------------------
// chess_clock_top
// Two-player chess clock core driving eight 7-segment digits directly.
//   CLK        : system clock, rising edge
//   CLR        : synchronous active-high clear of both counters and flags
//   CE         : time-base tick, one second per cycle with CE=1
//   SELECT     : 0 = player 1 runs, 1 = player 2 runs
//   STOP       : 1 = pause both players
//   OVERFLOW1/2: sticky saturation flags, either one ends the game
//   seg0_0..3  : player 1 digits (sec units, sec tens, min units, min tens)
//   seg1_0..3  : player 2 digits, same order; active-low {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module chess_clock_top
  import chess_clock_pkg::*;
(
  input  logic       CLK,
  input  logic       CLR,
  input  logic       CE,
  input  logic       SELECT,
  input  logic       STOP,
  output logic       OVERFLOW1,
  output logic       OVERFLOW2,
  output logic [6:0] seg0_0,
  output logic [6:0] seg0_1,
  output logic [6:0] seg0_2,
  output logic [6:0] seg0_3,
  output logic [6:0] seg1_0,
  output logic [6:0] seg1_1,
  output logic [6:0] seg1_2,
  output logic [6:0] seg1_3
);

  logic run;
  logic step1, step2;
  logic freeze;
  bcd_t p1SecOnes, p1SecTens, p1MinOnes, p1MinTens;
  bcd_t p2SecOnes, p2SecTens, p2MinOnes, p2MinTens;

  // Only the selected side sees the tick; a flag on either side stops both.
  assign run    = CE && !STOP;
  assign step1  = run && !SELECT;
  assign step2  = run && SELECT;
  assign freeze = OVERFLOW1 || OVERFLOW2;

  player_timer u_player1 (
    .clk_i      (CLK),
    .clr_i      (CLR),
    .step_i     (step1),
    .freeze_i   (freeze),
    .secOnes_o  (p1SecOnes),
    .secTens_o  (p1SecTens),
    .minOnes_o  (p1MinOnes),
    .minTens_o  (p1MinTens),
    .overflow_o (OVERFLOW1)
  );

  player_timer u_player2 (
    .clk_i      (CLK),
    .clr_i      (CLR),
    .step_i     (step2),
    .freeze_i   (freeze),
    .secOnes_o  (p2SecOnes),
    .secTens_o  (p2SecTens),
    .minOnes_o  (p2MinOnes),
    .minTens_o  (p2MinTens),
    .overflow_o (OVERFLOW2)
  );

  // Displays decode the counter registers directly, so a new digit shows
  // right after the edge that produced it.
  assign seg0_0 = bcd_to_seg(p1SecOnes);
  assign seg0_1 = bcd_to_seg(p1SecTens);
  assign seg0_2 = bcd_to_seg(p1MinOnes);
  assign seg0_3 = bcd_to_seg(p1MinTens);
  assign seg1_0 = bcd_to_seg(p2SecOnes);
  assign seg1_1 = bcd_to_seg(p2SecTens);
  assign seg1_2 = bcd_to_seg(p2MinOnes);
  assign seg1_3 = bcd_to_seg(p2MinTens);

endmodule

// File: tb/tb_chess_clock_top.sv
// -----------------------------------------------------------------------------
// tb_chess_clock_top
// Directed self-checking bench for chess_clock_top.
// -----------------------------------------------------------------------------
module tb_chess_clock_top;

  localparam logic [6:0] D0 = 7'h40;
  localparam logic [6:0] D1 = 7'h79;
  localparam logic [6:0] D3 = 7'h30;
  localparam logic [6:0] D5 = 7'h12;
  localparam logic [6:0] D9 = 7'h10;

  logic       CLK;
  logic       CLR;
  logic       CE;
  logic       SELECT;
  logic       STOP;
  logic       OVERFLOW1;
  logic       OVERFLOW2;
  logic [6:0] seg0_0, seg0_1, seg0_2, seg0_3;
  logic [6:0] seg1_0, seg1_1, seg1_2, seg1_3;

  int checks;
  int failures;

  chess_clock_top dut (
    .CLK       (CLK),
    .CLR       (CLR),
    .CE        (CE),
    .SELECT    (SELECT),
    .STOP      (STOP),
    .OVERFLOW1 (OVERFLOW1),
    .OVERFLOW2 (OVERFLOW2),
    .seg0_0    (seg0_0),
    .seg0_1    (seg0_1),
    .seg0_2    (seg0_2),
    .seg0_3    (seg0_3),
    .seg1_0    (seg1_0),
    .seg1_1    (seg1_1),
    .seg1_2    (seg1_2),
    .seg1_3    (seg1_3)
  );

  // Free-running 10-unit clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Single comparison point: count it and report any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Drive inputs away from the rising edge, hold them for the given number
  // of edges, then step 1 unit past the last edge so outputs have settled.
  task automatic applyStimulus(input logic clr, input logic ce,
                               input logic sel, input logic stop,
                               input int edges);
    @(negedge CLK);
    CLR    = clr;
    CE     = ce;
    SELECT = sel;
    STOP   = stop;
    repeat (edges) @(posedge CLK);
    #1;
  endtask

  // Compare one player's four digits, tens of minutes first.
  task automatic checkDisplay(input string tag, input int player,
                              input logic [6:0] mt, input logic [6:0] mu,
                              input logic [6:0] st, input logic [6:0] su);
    if (player == 1) begin
      checkOutput({tag, ".p1.minTens"}, {25'd0, seg0_3}, {25'd0, mt});
      checkOutput({tag, ".p1.minOnes"}, {25'd0, seg0_2}, {25'd0, mu});
      checkOutput({tag, ".p1.secTens"}, {25'd0, seg0_1}, {25'd0, st});
      checkOutput({tag, ".p1.secOnes"}, {25'd0, seg0_0}, {25'd0, su});
    end else begin
      checkOutput({tag, ".p2.minTens"}, {25'd0, seg1_3}, {25'd0, mt});
      checkOutput({tag, ".p2.minOnes"}, {25'd0, seg1_2}, {25'd0, mu});
      checkOutput({tag, ".p2.secTens"}, {25'd0, seg1_1}, {25'd0, st});
      checkOutput({tag, ".p2.secOnes"}, {25'd0, seg1_0}, {25'd0, su});
    end
  endtask

  task automatic checkFlags(input string tag, input logic f1, input logic f2);
    checkOutput({tag, ".ovf1"}, {31'd0, OVERFLOW1}, {31'd0, f1});
    checkOutput({tag, ".ovf2"}, {31'd0, OVERFLOW2}, {31'd0, f2});
  endtask

  // Directed scenario, each step with hand-computed display contents.
  initial begin
    checks   = 0;
    failures = 0;
    CLR      = 1'b1;
    CE       = 1'b0;
    SELECT   = 1'b0;
    STOP     = 1'b0;

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3);
    checkDisplay("reset", 1, D0, D0, D0, D0);
    checkDisplay("reset", 2, D0, D0, D0, D0);
    checkFlags("reset", 1'b0, 1'b0);

    $display("[TB] player 1 runs 3 s");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3);
    checkDisplay("p1run", 1, D0, D0, D0, D3);
    checkDisplay("p1run", 2, D0, D0, D0, D0);

    $display("[TB] player 2 runs 60 s, carry into minutes");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 60);
    checkDisplay("p2carry", 2, D0, D1, D0, D0);
    checkDisplay("p2carry", 1, D0, D0, D0, D3);

    $display("[TB] STOP and CE gating");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 10);
    checkDisplay("stop", 2, D0, D1, D0, D0);
    checkDisplay("stop", 1, D0, D0, D0, D3);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 10);
    checkDisplay("noce", 2, D0, D1, D0, D0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1);
    checkDisplay("resume", 2, D0, D1, D0, D1);
    checkDisplay("resume", 1, D0, D0, D0, D3);

    $display("[TB] CLR beats CE on the same edge");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1);
    checkDisplay("clrce", 1, D0, D0, D0, D0);
    checkDisplay("clrce", 2, D0, D0, D0, D0);

    $display("[TB] player 1 to saturation");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 5999);
    checkDisplay("p1max", 1, D9, D9, D5, D9);
    checkFlags("p1max", 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1);
    checkDisplay("p1ovf", 1, D9, D9, D5, D9);
    checkFlags("p1ovf", 1'b1, 1'b0);

    $display("[TB] player 2 frozen after game over");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 5);
    checkDisplay("frozen", 2, D0, D0, D0, D0);
    checkDisplay("frozen", 1, D9, D9, D5, D9);
    checkFlags("frozen", 1'b1, 1'b0);

    $display("[TB] clear mid-operation");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1);
    checkDisplay("midclr", 1, D0, D0, D0, D0);
    checkDisplay("midclr", 2, D0, D0, D0, D0);
    checkFlags("midclr", 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1);
    checkDisplay("afterclr", 1, D0, D0, D0, D1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
